// File: rtl/onchip_frame_writer_pkg.sv
// Shared types and constants for the on-chip frame writer.
// Covers the FSM state encoding, the memory lane-enable patterns and the word width.
package onchip_frame_writer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int         WORD_W  = 32;
    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

endpackage

// File: rtl/onchip_frame_writer_if.sv
// Pixel stream sink plus frame-memory write port of the frame writer.
// The master modport is the writer's view: it sinks the stream and masters the memory.
interface onchip_frame_writer_if
    import onchip_frame_writer_pkg::*;
#(
    parameter int PIXEL_W = 16,
    parameter int ADDR_W  = 15
);
    logic [PIXEL_W-1:0] snk_data;
    logic               snk_valid;
    logic               snk_sop;
    logic               snk_eop;
    logic               snk_ready;
    logic [ADDR_W-1:0]  mem_address;
    logic [3:0]         mem_byteenable;
    logic               mem_chipselect;
    logic               mem_write;
    logic [WORD_W-1:0]  mem_writedata;
    logic               mem_clken;

    modport master (
        input  snk_data, snk_valid, snk_sop, snk_eop,
        output snk_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken
    );

    modport slave (
        output snk_data, snk_valid, snk_sop, snk_eop,
        input  snk_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken
    );

endinterface

// File: rtl/onchip_frame_writer_pixel_packer.sv
// Packs pairs of 16-bit pixels into 32-bit words; a frame's last pixel on lane 0
// is flushed alone in the low half.
module onchip_frame_writer_pixel_packer
    import onchip_frame_writer_pkg::*;
#(
    parameter int PIXEL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic               pix_start,
    input  logic               pix_last,
    input  logic               discard,
    input  logic [PIXEL_W-1:0] pix_data,
    output logic               word_valid,
    output logic [WORD_W-1:0]  word_data,
    output logic [3:0]         word_be
);

    logic               lane_r;
    logic               lane_nxt_s;
    logic [PIXEL_W-1:0] hold_r;
    logic [PIXEL_W-1:0] hold_nxt_s;

    // Lane selection and word assembly; a start pixel always lands in lane 0.
    always_comb begin
        lane_nxt_s = lane_r;
        hold_nxt_s = hold_r;
        word_valid = 1'b0;
        word_data  = {WORD_W{1'b0}};
        word_be    = 4'b0000;
        if (discard) begin
            lane_nxt_s = 1'b0;
        end else if (pix_valid) begin
            if (lane_r && !pix_start) begin
                word_valid = 1'b1;
                word_data  = {pix_data, hold_r};
                word_be    = BE_FULL;
                lane_nxt_s = 1'b0;
            end else if (pix_last) begin
                word_valid = 1'b1;
                word_data  = {{PIXEL_W{1'b0}}, pix_data};
                word_be    = BE_LOW;
                lane_nxt_s = 1'b0;
            end else begin
                hold_nxt_s = pix_data;
                lane_nxt_s = 1'b1;
            end
        end else begin
            lane_nxt_s = lane_r;
        end
    end

    // Lane flag and low-pixel holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_r <= 1'b0;
            hold_r <= {PIXEL_W{1'b0}};
        end else begin
            lane_r <= lane_nxt_s;
            hold_r <= hold_nxt_s;
        end
    end

endmodule

// File: rtl/onchip_frame_writer.sv
// Writes one frame of 16-bit pixels, packed two per word, into the on-chip frame
// memory from address 0 and reports completion, word count and overflow.
module onchip_frame_writer
    import onchip_frame_writer_pkg::*;
#(
    parameter int PIXEL_W     = 16,
    parameter int ADDR_W      = 15,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    onchip_frame_writer_if.master bus,
    output logic                  frame_done,
    output logic                  overflow,
    output logic [ADDR_W:0]       words_written
);

    localparam logic [ADDR_W:0] FRAME_WORDS_C = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W:0] ONE_C         = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_nxt_s;
    logic              beat_s;
    logic              start_s;
    logic              pack_valid_s;
    logic              discard_s;
    logic              done_nxt_s;
    logic              word_valid_s;
    logic [WORD_W-1:0] word_data_s;
    logic [3:0]        word_be_s;
    logic [ADDR_W:0]   base_count_s;
    logic              ovf_hit_s;
    logic              write_s;

    logic [ADDR_W:0]   words_written_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [WORD_W-1:0] mem_writedata_r;
    logic [3:0]        mem_byteenable_r;
    logic              mem_write_r;
    logic              mem_clken_r;
    logic              frame_done_r;
    logic              overflow_r;

    // mem_clken_r doubles as "out of reset" so snk_ready stays low during reset.
    assign bus.snk_ready = enable & mem_clken_r;
    assign beat_s        = bus.snk_valid & bus.snk_ready;
    assign start_s       = beat_s & bus.snk_sop;

    // A frame start restarts counting from zero in the same beat it is accepted.
    assign base_count_s = start_s ? {(ADDR_W+1){1'b0}} : words_written_r;
    assign ovf_hit_s    = word_valid_s & (base_count_s == FRAME_WORDS_C);
    assign write_s      = word_valid_s & ~ovf_hit_s;

    onchip_frame_writer_pixel_packer #(
        .PIXEL_W (PIXEL_W)
    ) u_pixel_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pack_valid_s),
        .pix_start  (start_s),
        .pix_last   (bus.snk_eop),
        .discard    (discard_s),
        .pix_data   (bus.snk_data),
        .word_valid (word_valid_s),
        .word_data  (word_data_s),
        .word_be    (word_be_s)
    );

    // Frame FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame FSM: beats outside a frame are dropped; after overflow only eop or sop matter.
    always_comb begin
        state_nxt_s  = state_r;
        pack_valid_s = 1'b0;
        discard_s    = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    pack_valid_s = 1'b1;
                    done_nxt_s   = bus.snk_eop;
                    state_nxt_s  = bus.snk_eop ? IDLE : FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (!enable) begin
                    discard_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (start_s) begin
                    pack_valid_s = 1'b1;
                    done_nxt_s   = bus.snk_eop;
                    state_nxt_s  = bus.snk_eop ? IDLE : FILL;
                end else if (beat_s) begin
                    pack_valid_s = ~overflow_r;
                    done_nxt_s   = bus.snk_eop;
                    state_nxt_s  = bus.snk_eop ? IDLE : FILL;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default: begin
                discard_s   = 1'b1;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Memory write port, word counter and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_clken_r      <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_address_r    <= {ADDR_W{1'b0}};
            mem_writedata_r  <= {WORD_W{1'b0}};
            mem_byteenable_r <= 4'b0000;
            words_written_r  <= {(ADDR_W+1){1'b0}};
            frame_done_r     <= 1'b0;
            overflow_r       <= 1'b0;
        end else begin
            mem_clken_r  <= 1'b1;
            mem_write_r  <= write_s;
            frame_done_r <= done_nxt_s;
            if (write_s) begin
                mem_address_r    <= base_count_s[ADDR_W-1:0];
                mem_writedata_r  <= word_data_s;
                mem_byteenable_r <= word_be_s;
                words_written_r  <= base_count_s + ONE_C;
            end else if (start_s) begin
                words_written_r <= {(ADDR_W+1){1'b0}};
            end else begin
                words_written_r <= words_written_r;
            end
            if (start_s) begin
                overflow_r <= 1'b0;
            end else if (ovf_hit_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign bus.mem_clken      = mem_clken_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_chipselect = mem_write_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_writedata  = mem_writedata_r;
    assign bus.mem_byteenable = mem_byteenable_r;
    assign frame_done         = frame_done_r;
    assign overflow           = overflow_r;
    assign words_written      = words_written_r;

endmodule

// File: tb/tb_onchip_frame_writer.sv
// Directed bench for onchip_frame_writer with a two-word frame capacity so the
// overflow path is reachable with short frames.
module tb_onchip_frame_writer;

    localparam int ADDR_W      = 15;
    localparam int FRAME_WORDS = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              frame_done;
    logic              overflow;
    logic [ADDR_W:0]   words_written;
    int                checks_cnt = 0;
    int                errors_cnt = 0;

    onchip_frame_writer_if #(.PIXEL_W(16), .ADDR_W(ADDR_W)) bus_if ();

    onchip_frame_writer #(
        .PIXEL_W     (16),
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .bus           (bus_if),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] pix, input logic sop, input logic eop);
        @(negedge clk);
        bus_if.snk_data  = pix;
        bus_if.snk_valid = 1'b1;
        bus_if.snk_sop   = sop;
        bus_if.snk_eop   = eop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus_if.snk_valid = 1'b0;
        bus_if.snk_sop   = 1'b0;
        bus_if.snk_eop   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] data, input logic [31:0] mask,
                                input logic [3:0] be, input logic done, input logic [ADDR_W:0] ww);
        check_value({tag, "_wr"},   32'(bus_if.mem_write), 32'd1);
        check_value({tag, "_cs"},   32'(bus_if.mem_chipselect), 32'd1);
        check_value({tag, "_addr"}, 32'(bus_if.mem_address), 32'(addr));
        check_value({tag, "_data"}, bus_if.mem_writedata & mask, data & mask);
        check_value({tag, "_be"},   32'(bus_if.mem_byteenable), 32'(be));
        check_value({tag, "_done"}, 32'(frame_done), 32'(done));
        check_value({tag, "_ww"},   32'(words_written), 32'(ww));
    endtask

    task automatic expect_quiet(input string tag, input logic done, input logic [ADDR_W:0] ww);
        check_value({tag, "_wr"},   32'(bus_if.mem_write), 32'd0);
        check_value({tag, "_cs"},   32'(bus_if.mem_chipselect), 32'd0);
        check_value({tag, "_done"}, 32'(frame_done), 32'(done));
        check_value({tag, "_ww"},   32'(words_written), 32'(ww));
    endtask

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b1;
        bus_if.snk_data  = 16'h0000;
        bus_if.snk_valid = 1'b0;
        bus_if.snk_sop   = 1'b0;
        bus_if.snk_eop   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_quiet("rst", 1'b0, 16'd0);
        check_value("rst_clken", 32'(bus_if.mem_clken), 32'd0);
        check_value("rst_ready", 32'(bus_if.snk_ready), 32'd0);
        check_value("rst_ovf",   32'(overflow), 32'd0);
        check_value("rst_addr",  32'(bus_if.mem_address), 32'd0);
        check_value("rst_data",  bus_if.mem_writedata, 32'd0);
        check_value("rst_be",    32'(bus_if.mem_byteenable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("rel_clken", 32'(bus_if.mem_clken), 32'd1);
        check_value("rel_ready", 32'(bus_if.snk_ready), 32'd1);

        // four-pixel frame
        send_beat(16'h1111, 1'b1, 1'b0); expect_quiet("t1_p0", 1'b0, 16'd0);
        send_beat(16'h2222, 1'b0, 1'b0); expect_write("t1_w0", 15'd0, 32'h22221111, 32'hFFFFFFFF, 4'b1111, 1'b0, 16'd1);
        send_beat(16'h3333, 1'b0, 1'b0); expect_quiet("t1_p2", 1'b0, 16'd1);
        send_beat(16'h4444, 1'b0, 1'b1); expect_write("t1_w1", 15'd1, 32'h44443333, 32'hFFFFFFFF, 4'b1111, 1'b1, 16'd2);
        idle_cycle();                    expect_quiet("t1_end", 1'b0, 16'd2);

        // three-pixel frame flushes a half word
        send_beat(16'hAAAA, 1'b1, 1'b0); expect_quiet("t2_p0", 1'b0, 16'd0);
        send_beat(16'hBBBB, 1'b0, 1'b0); expect_write("t2_w0", 15'd0, 32'hBBBBAAAA, 32'hFFFFFFFF, 4'b1111, 1'b0, 16'd1);
        send_beat(16'hCCCC, 1'b0, 1'b1); expect_write("t2_w1", 15'd1, 32'h0000CCCC, 32'h0000FFFF, 4'b0011, 1'b1, 16'd2);
        idle_cycle();

        // seven pixels into a two-word frame
        send_beat(16'h0101, 1'b1, 1'b0); expect_quiet("t3_p0", 1'b0, 16'd0);
        check_value("t3_ovf0", 32'(overflow), 32'd0);
        send_beat(16'h0202, 1'b0, 1'b0); expect_write("t3_w0", 15'd0, 32'h02020101, 32'hFFFFFFFF, 4'b1111, 1'b0, 16'd1);
        send_beat(16'h0303, 1'b0, 1'b0); expect_quiet("t3_p2", 1'b0, 16'd1);
        send_beat(16'h0404, 1'b0, 1'b0); expect_write("t3_w1", 15'd1, 32'h04040303, 32'hFFFFFFFF, 4'b1111, 1'b0, 16'd2);
        send_beat(16'h0505, 1'b0, 1'b0); expect_quiet("t3_p4", 1'b0, 16'd2);
        send_beat(16'h0606, 1'b0, 1'b0); expect_quiet("t3_w2", 1'b0, 16'd2);
        check_value("t3_ovf1", 32'(overflow), 32'd1);
        send_beat(16'h0707, 1'b0, 1'b1); expect_quiet("t3_eop", 1'b1, 16'd2);
        idle_cycle();
        check_value("t3_ovf_sticky", 32'(overflow), 32'd1);
        send_beat(16'h5555, 1'b1, 1'b0); expect_quiet("t3_new", 1'b0, 16'd0);
        check_value("t3_ovf_clr", 32'(overflow), 32'd0);
        send_beat(16'h6666, 1'b0, 1'b1); expect_write("t3_nw", 15'd0, 32'h66665555, 32'hFFFFFFFF, 4'b1111, 1'b1, 16'd1);
        idle_cycle();

        // pixels before sop are dropped; mid-frame sop restarts at address 0
        send_beat(16'h0A0A, 1'b0, 1'b0); expect_quiet("t4_pre0", 1'b0, 16'd1);
        send_beat(16'h0B0B, 1'b0, 1'b1); expect_quiet("t4_pre1", 1'b0, 16'd1);
        send_beat(16'h1001, 1'b1, 1'b0); expect_quiet("t4_p0", 1'b0, 16'd0);
        send_beat(16'h1002, 1'b0, 1'b0); expect_write("t4_w0", 15'd0, 32'h10021001, 32'hFFFFFFFF, 4'b1111, 1'b0, 16'd1);
        send_beat(16'h1003, 1'b0, 1'b0); expect_quiet("t4_p2", 1'b0, 16'd1);
        send_beat(16'h2001, 1'b1, 1'b0); expect_quiet("t4_sop", 1'b0, 16'd0);
        send_beat(16'h2002, 1'b0, 1'b1); expect_write("t4_nw", 15'd0, 32'h20022001, 32'hFFFFFFFF, 4'b1111, 1'b1, 16'd1);
        idle_cycle();

        // single-beat frame
        send_beat(16'hABCD, 1'b1, 1'b1); expect_write("t5_w0", 15'd0, 32'h0000ABCD, 32'h0000FFFF, 4'b0011, 1'b1, 16'd1);
        idle_cycle();                    expect_quiet("t5_end", 1'b0, 16'd1);

        // enable low in FILL drops the partial word and the frame
        send_beat(16'h3001, 1'b1, 1'b0); expect_quiet("t6_p0", 1'b0, 16'd0);
        @(negedge clk);
        enable           = 1'b0;
        bus_if.snk_valid = 1'b0;
        @(posedge clk);
        #1;
        check_value("t6_ready", 32'(bus_if.snk_ready), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        send_beat(16'h3002, 1'b0, 1'b1); expect_quiet("t6_drop", 1'b0, 16'd0);
        idle_cycle();

        // asynchronous reset during a write cycle
        send_beat(16'h4001, 1'b1, 1'b0);
        send_beat(16'h4002, 1'b0, 1'b0);
        check_value("t7_pre_wr", 32'(bus_if.mem_write), 32'd1);
        #2;
        reset_n          = 1'b0;
        bus_if.snk_valid = 1'b0;
        #1;
        expect_quiet("t7_rst", 1'b0, 16'd0);
        check_value("t7_addr",  32'(bus_if.mem_address), 32'd0);
        check_value("t7_data",  bus_if.mem_writedata, 32'd0);
        check_value("t7_clken", 32'(bus_if.mem_clken), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(16'h5001, 1'b1, 1'b0); expect_quiet("t7_p0", 1'b0, 16'd0);
        send_beat(16'h5002, 1'b0, 1'b1); expect_write("t7_w0", 15'd0, 32'h50025001, 32'hFFFFFFFF, 4'b1111, 1'b1, 16'd1);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/onchip_frame_writer.md
# onchip_frame_writer

Streaming write stage feeding the 32-bit single-port on-chip frame memory (32768 words, byte-enabled, no wait-request). Accepts one frame of 16-bit pixels on an Avalon-ST sink, packs two pixels per 32-bit word and issues sequential single-cycle Avalon-MM writes from word address 0. Reports frame completion, word count and overflow to the control CPU.

## Interface
Parameters:
- PIXEL_W, 16, pixel width; fixed at 16, two pixels per word
- ADDR_W, 15, memory word-address width
- FRAME_WORDS, 19200, word capacity of one frame (1 ≤ FRAME_WORDS ≤ 2^ADDR_W)

Ports:
- clk  in  1  single clock, shared with the memory
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 0 forces IDLE after the current cycle and deasserts snk_ready
- snk_data  in  16  pixel
- snk_valid  in  1  pixel valid
- snk_sop  in  1  first pixel of frame
- snk_eop  in  1  last pixel of frame
- snk_ready  out  1  = enable; no other backpressure
- mem_address  out  ADDR_W  word address
- mem_byteenable  out  4  lane enables
- mem_chipselect  out  1  asserted with mem_write
- mem_write  out  1  one-cycle write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  constant 1 after reset
- frame_done  out  1  one-cycle pulse
- overflow  out  1  sticky until next accepted sop
- words_written  out  ADDR_W+1  words written in current/last frame

## Operation
- Beat = snk_valid & snk_ready. States: IDLE, FILL.
- IDLE: beats without sop are dropped. Beat with sop: pixel to lane 0 (bits 15:0), address pointer and words_written cleared, overflow cleared, go FILL. sop+eop same beat: single-pixel frame, write word with byteenable 0011, stay IDLE.
- FILL: lane toggles per beat; lane-1 pixel goes to bits 31:16 and completes a word (byteenable 1111). eop on a lane-0 pixel flushes partial word (byteenable 0011). eop → IDLE.
- sop in FILL: pending partial word discarded, treated as new frame start (restart at address 0).
- Each completed word writes to pointer, then pointer and words_written increment.
- Overflow: word completing when words_written == FRAME_WORDS is not written; overflow set; remaining pixels dropped until eop; frame_done still pulses at eop.
- enable low in FILL: partial word discarded, → IDLE, no frame_done.

## Timing
- Reset values: all outputs 0 (mem_clken 0 during reset, 1 from first clock after release), state IDLE, lane 0.
- Write latency: word-completing beat in cycle N → mem_write/mem_chipselect high in N+1 with address, data, byteenable registered; all low next cycle unless another word completes. Max one write per 2 beats except eop/sop-flush cases, max one per cycle.
- frame_done pulses in cycle N+1 after the eop beat, coincident with the final write (if any).
- words_written updates in the same cycle as its write.
- Reset mid-frame: outputs clear immediately (asynchronous), in-flight write suppressed.

## Structure
- Package onchip_frame_writer_pkg: state enum (IDLE, FILL), byteenable constants BE_FULL=4'b1111, BE_LOW=4'b0011, WORD_W=32.
- Sub-module pixel_packer: lane toggle, holding register, emits word + byteenable + word_valid; top holds FSM, address counter, overflow and status.

## Test plan
- 4-pixel frame 0x1111,0x2222,0x3333,0x4444 (sop first, eop last) → writes addr 0 data 0x22221111 BE 1111, addr 1 0x44443333 BE 1111; frame_done with second write; words_written=2.
- 3-pixel frame A,B,C → addr 0 {B,A} BE 1111, addr 1 {0x????,C} BE 0011; words_written=2.
- FRAME_WORDS=2, 6-pixel frame → two writes, overflow=1 after third word, no write to addr 2, frame_done at eop; next sop clears overflow.
- Pixels before sop, then sop mid-frame after 3 pixels → pre-sop pixels dropped, partial word discarded, new frame writes from addr 0.
- Single beat sop+eop 0xABCD → one write addr 0 BE 0011 data[15:0]=0xABCD, frame_done same cycle.
- reset_n low during write cycle → mem_write drops immediately, all outputs 0; post-reset frame starts at addr 0.
